// File: rtl/definitions.sv
// Shared memory-access types and helpers used by the RAM and by the masters that drive it.
// No logic of its own.
package definitions;

    localparam int unsigned MEM_ADDR_W = 32;
    localparam int unsigned MEM_DATA_W = 32;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_access_size_t;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_t;

    // Number of bytes touched by an access; the unused encoding behaves as a word.
    function automatic logic [2:0] access_bytes(input mem_access_size_t size);
        case (size)
            BYTE:    return 3'd1;
            HALF:    return 3'd2;
            WORD:    return 3'd4;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/memory_array_interface.sv
// Memory port bundle: one combinational read channel and one clocked write channel.
// No handshake; the responder never stalls.
interface memory_array_interface;
    import definitions::*;

    logic [MEM_ADDR_W-1:0] rd_addr;
    mem_access_size_t      rd_size;
    logic [MEM_DATA_W-1:0] rd_data;
    logic [MEM_ADDR_W-1:0] wr_addr;
    logic [MEM_DATA_W-1:0] wr_data;
    mem_access_size_t      wr_size;
    logic                  wr_enable;

    modport master (
        output rd_addr, rd_size, wr_addr, wr_data, wr_size, wr_enable,
        input  rd_data
    );

    modport slave (
        input  rd_addr, rd_size, wr_addr, wr_data, wr_size, wr_enable,
        output rd_data
    );

endinterface

// File: rtl/memory_array_bank.sv
// One byte-wide bank: asynchronous read, write committed on the clock edge when wr_en is set.
// Read latency 0, write visible the cycle after; never stalls.
module memory_array_bank #(
    parameter int unsigned ROWS = 16384,
    parameter int unsigned RW   = 14
) (
    input  logic          clk,
    input  logic [RW-1:0] rd_row,
    output logic [7:0]    rd_dat,
    input  logic          wr_en,
    input  logic [RW-1:0] wr_row,
    input  logic [7:0]    wr_dat
);

    logic [7:0] store [ROWS];

    assign rd_dat = store[rd_row];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            store[wr_row] <= wr_dat;
        end
    end

endmodule

// File: rtl/memory_array.sv
// Byte-addressable RAM with misaligned/wrapping accesses and a post-reset clear sequencer.
// Read latency 0, write visible next cycle; no backpressure, accesses ignored until init_done.
module memory_array
    import definitions::*;
#(
    parameter int unsigned SIZE           = 65536,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    memory_array_interface.slave mem,
    output logic                 init_done
);

    localparam int unsigned ROWS = SIZE / 4;
    localparam int unsigned AW   = $clog2(SIZE);
    localparam int unsigned RW   = AW - 2;

    clr_state_t    state;
    clr_state_t    state_nxt;
    logic [RW-1:0] clr_row;
    logic [RW-1:0] clr_row_nxt;
    logic          clear_act;

    logic [RW-1:0] rd_row;
    logic [RW-1:0] rd_row_inc;
    logic [1:0]    rd_off;
    logic [2:0]    rd_len;
    logic [RW-1:0] wr_row;
    logic [RW-1:0] wr_row_inc;
    logic [1:0]    wr_off;
    logic [2:0]    wr_len;
    logic          wr_accept;

    logic [3:0][7:0] bank_rd_dat;
    logic [31:0]     rd_word;
    logic            unused_addr_bits;

    // Bits above the array size alias onto the same storage.
    assign unused_addr_bits = ^{mem.rd_addr[MEM_ADDR_W-1:AW], mem.wr_addr[MEM_ADDR_W-1:AW]};

    assign rd_off     = mem.rd_addr[1:0];
    assign rd_row     = mem.rd_addr[AW-1:2];
    assign rd_row_inc = rd_row + RW'(1);
    assign rd_len     = access_bytes(mem.rd_size);

    assign wr_off     = mem.wr_addr[1:0];
    assign wr_row     = mem.wr_addr[AW-1:2];
    assign wr_row_inc = wr_row + RW'(1);
    assign wr_len     = access_bytes(mem.wr_size);
    assign wr_accept  = mem.wr_enable && init_done;

    // Banks below the start offset hold the bytes that spill into the next row.
    for (genvar b = 0; b < 4; b++) begin : g_bank
        localparam logic [1:0] LANE = 2'(b);

        logic [1:0]    wr_idx;
        logic [RW-1:0] bank_rd_row;
        logic          bank_wr_en;
        logic [RW-1:0] bank_wr_row;
        logic [7:0]    bank_wr_dat;

        assign wr_idx      = LANE - wr_off;
        assign bank_rd_row = (LANE < rd_off) ? rd_row_inc : rd_row;

        always_comb begin
            bank_wr_en  = 1'b0;
            bank_wr_row = wr_row;
            bank_wr_dat = mem.wr_data[8*wr_idx +: 8];
            if (clear_act) begin
                bank_wr_en  = !reset;
                bank_wr_row = clr_row;
                bank_wr_dat = 8'h00;
            end else begin
                bank_wr_en  = wr_accept && ({1'b0, wr_idx} < wr_len);
                bank_wr_row = (LANE < wr_off) ? wr_row_inc : wr_row;
            end
        end

        memory_array_bank #(
            .ROWS (ROWS),
            .RW   (RW)
        ) u_bank (
            .clk    (clk),
            .rd_row (bank_rd_row),
            .rd_dat (bank_rd_dat[b]),
            .wr_en  (bank_wr_en),
            .wr_row (bank_wr_row),
            .wr_dat (bank_wr_dat)
        );
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < rd_len) begin
                rd_word[8*i +: 8] = bank_rd_dat[rd_off + 2'(i)];
            end
        end
    end

    assign mem.rd_data = init_done ? rd_word : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CLEAR_ON_RESET ? CLEAR : READY;
            clr_row   <= '0;
            init_done <= !CLEAR_ON_RESET;
        end else begin
            state     <= state_nxt;
            clr_row   <= clr_row_nxt;
            init_done <= (state_nxt == READY);
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_row_nxt = clr_row;
        clear_act   = 1'b0;
        case (state)
            CLEAR: begin
                clear_act   = 1'b1;
                clr_row_nxt = clr_row + RW'(1);
                if (clr_row == RW'(ROWS - 1)) begin
                    state_nxt = READY;
                end
            end
            READY: begin
                state_nxt = READY;
            end
            default: begin
                state_nxt = READY;
            end
        endcase
    end

endmodule

// File: tb/tb_memory_array.sv
// Two 64-byte arrays (clear on / clear off) on one shared access stream, checked against byte-array models.
module tb_memory_array;
    import definitions::*;

    localparam int SZ = 64;

    logic             clk = 1'b0;
    logic             rst0;
    logic             rst1;
    logic [31:0]      rd_addr;
    mem_access_size_t rd_size;
    logic [31:0]      wr_addr;
    logic [31:0]      wr_data;
    mem_access_size_t wr_size;
    logic             wr_enable;
    logic             done0;
    logic             done1;

    int tests = 0;
    int fails = 0;

    memory_array_interface if0 ();
    memory_array_interface if1 ();

    assign if0.rd_addr   = rd_addr;
    assign if0.rd_size   = rd_size;
    assign if0.wr_addr   = wr_addr;
    assign if0.wr_data   = wr_data;
    assign if0.wr_size   = wr_size;
    assign if0.wr_enable = wr_enable;
    assign if1.rd_addr   = rd_addr;
    assign if1.rd_size   = rd_size;
    assign if1.wr_addr   = wr_addr;
    assign if1.wr_data   = wr_data;
    assign if1.wr_size   = wr_size;
    assign if1.wr_enable = wr_enable;

    memory_array #(.SIZE(SZ), .CLEAR_ON_RESET(1'b1)) dut0 (
        .clk       (clk),
        .reset     (rst0),
        .mem       (if0),
        .init_done (done0)
    );

    memory_array #(.SIZE(SZ), .CLEAR_ON_RESET(1'b0)) dut1 (
        .clk       (clk),
        .reset     (rst1),
        .mem       (if1),
        .init_done (done1)
    );

    always #5 clk = ~clk;

    // Reference model: plain byte arrays, a post-reset cycle counter, and known-byte flags.
    logic [7:0] m0 [SZ];
    logic [7:0] m1 [SZ];
    bit         k1 [SZ];
    int         cnt0 = 0;
    bit         v0 = 1'b0;
    bit         v1 = 1'b0;

    function automatic int tb_len(input mem_access_size_t s);
        if (s == BYTE) return 1;
        if (s == HALF) return 2;
        return 4;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst0) begin
            cnt0 = 0;
            v0   = 1'b1;
            for (int a = 0; a < SZ; a++) m0[a] = 8'h00;
        end else begin
            if (v0 && cnt0 >= SZ / 4 && wr_enable === 1'b1) begin
                for (int i = 0; i < tb_len(wr_size); i++)
                    m0[(wr_addr + 32'(i)) % SZ] = wr_data[8*i +: 8];
            end
            if (cnt0 < SZ / 4) cnt0++;
        end
        if (v1 && wr_enable === 1'b1) begin
            for (int i = 0; i < tb_len(wr_size); i++) begin
                m1[(wr_addr + 32'(i)) % SZ] = wr_data[8*i +: 8];
                k1[(wr_addr + 32'(i)) % SZ] = 1'b1;
            end
        end
        if (rst1) v1 = 1'b1;
    end

    logic [31:0] exp0;
    logic [31:0] exp1;
    bit          kn1;

    always @(negedge clk) begin
        if (v0) begin
            check("done0", {31'b0, done0}, {31'b0, cnt0 >= SZ / 4});
            exp0 = '0;
            if (cnt0 >= SZ / 4) begin
                for (int i = 0; i < tb_len(rd_size); i++)
                    exp0 = exp0 | (32'(m0[(rd_addr + 32'(i)) % SZ]) << (8 * i));
            end
            check("rd0", if0.rd_data, exp0);
        end
        if (v1) begin
            check("done1", {31'b0, done1}, 32'd1);
            exp1 = '0;
            kn1  = 1'b1;
            for (int i = 0; i < tb_len(rd_size); i++) begin
                if (!k1[(rd_addr + 32'(i)) % SZ]) kn1 = 1'b0;
                exp1 = exp1 | (32'(m1[(rd_addr + 32'(i)) % SZ]) << (8 * i));
            end
            if (kn1) check("rd1", if1.rd_data, exp1);
        end
    end

    task automatic drive(input logic we, input logic [31:0] wa, input mem_access_size_t ws,
                         input logic [31:0] wd, input logic [31:0] ra, input mem_access_size_t rs);
        @(posedge clk);
        #1;
        wr_enable = we;
        wr_addr   = wa;
        wr_size   = ws;
        wr_data   = wd;
        rd_addr   = ra;
        rd_size   = rs;
    endtask

    task automatic peek(input string name, input logic [31:0] exp);
        @(negedge clk);
        check(name, if0.rd_data, exp);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst0 = 1'b1;
        rst1 = 1'b1;
        wr_enable = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        wr_size = WORD;
        rd_addr = '0;
        rd_size = WORD;
        for (int a = 0; a < SZ; a++) begin
            m1[a] = 8'h00;
            k1[a] = 1'b0;
        end
        repeat (3) @(posedge clk);

        // Release both resets; prefill the no-clear array while the other one clears.
        #1;
        rst0 = 1'b0;
        rst1 = 1'b0;
        wr_enable = 1'b1;
        wr_addr = 32'h0;
        wr_data = $urandom;
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check("done1_immediate", {31'b0, done1}, 32'd1);
                check("done0_cycle0", {31'b0, done0}, 32'd0);
            end
            if (k == 5) check("rd_during_clear", if0.rd_data, 32'h0);
            if (k == 15) check("done0_cycle15", {31'b0, done0}, 32'd0);
            if (k == 16) begin
                check("done0_cycle16", {31'b0, done0}, 32'd1);
                check("rd_after_clear", if0.rd_data, 32'h0);
            end
            @(posedge clk);
            #1;
            if (k < 15) begin
                wr_addr = 32'(4 * (k + 1));
                wr_data = $urandom;
            end else begin
                wr_enable = 1'b0;
            end
        end

        drive(1'b0, 32'h0, WORD, 32'h0, 32'h3C, WORD);        peek("write_during_clear_dropped", 32'h0);
        drive(1'b1, 32'h0E, WORD, 32'h11223344, 32'h0, BYTE);
        drive(1'b0, 32'h0, WORD, 32'h0, 32'h0C, WORD);        peek("misaligned_lo", 32'h33440000);
        drive(1'b0, 32'h0, WORD, 32'h0, 32'h10, WORD);        peek("misaligned_hi", 32'h00001122);
        drive(1'b1, 32'h10, WORD, 32'hDEADBEEF, 32'h0, BYTE);
        drive(1'b0, 32'h0, WORD, 32'h0, 32'h10, BYTE);        peek("byte_read", 32'h000000EF);
        drive(1'b0, 32'h0, WORD, 32'h0, 32'h12, HALF);        peek("half_read", 32'h0000DEAD);
        drive(1'b0, 32'h0, WORD, 32'h0, 32'h10, WORD);        peek("word_read", 32'hDEADBEEF);
        drive(1'b1, 32'h3F, HALF, 32'h0000A55A, 32'h3F, BYTE); peek("wrap_same_cycle_old", 32'h0);
        drive(1'b0, 32'h0, WORD, 32'h0, 32'h3F, BYTE);        peek("wrap_byte_3f", 32'h5A);
        drive(1'b0, 32'h0, WORD, 32'h0, 32'h00, BYTE);        peek("wrap_byte_00", 32'hA5);
        drive(1'b0, 32'h0, WORD, 32'h0, 32'h1003F, BYTE);     peek("alias_1003f", 32'h5A);
        drive(1'b0, 32'h0, WORD, 32'h0, 32'h3F, HALF);        peek("wrap_half", 32'hA55A);
        drive(1'b1, 32'h20, WORD, 32'h1, 32'h20, WORD);       peek("same_cycle_old", 32'h0);
        drive(1'b0, 32'h0, WORD, 32'h0, 32'h20, WORD);        peek("same_cycle_new", 32'h1);

        // Reset pulsed in cycle 5 of a clear restarts the full clear.
        @(posedge clk); #1 rst0 = 1'b1;
        @(posedge clk); #1 rst0 = 1'b0;
        wr_enable = 1'b1; wr_addr = 32'h24; wr_size = WORD; wr_data = 32'hCAFEF00D;
        repeat (5) @(posedge clk);
        #1 rst0 = 1'b1;
        wr_enable = 1'b0;
        @(posedge clk); #1 rst0 = 1'b0;
        rd_addr = 32'h20; rd_size = WORD;
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            if (k == 15) check("restart_done_cycle15", {31'b0, done0}, 32'd0);
            if (k == 16) begin
                check("restart_done_cycle16", {31'b0, done0}, 32'd1);
                check("restart_recleared", if0.rd_data, 32'h0);
            end
        end
        drive(1'b0, 32'h0, WORD, 32'h0, 32'h24, WORD);        peek("dropped_mid_clear", 32'h0);

        // No-clear array keeps its contents across reset.
        @(posedge clk); #1 rst1 = 1'b1; rd_addr = 32'h20; rd_size = WORD;
        @(negedge clk); check("done1_in_reset", {31'b0, done1}, 32'd1);
        @(posedge clk); #1 rst1 = 1'b0;
        @(negedge clk);
        check("done1_after_reset", {31'b0, done1}, 32'd1);
        check("retained_after_reset", if1.rd_data, 32'h1);

        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)),
                  (n % 4 == 0) ? $urandom : 32'($urandom_range(0, SZ - 1)),
                  mem_access_size_t'(2'($urandom_range(0, 2))),
                  $urandom,
                  (n % 5 == 0) ? $urandom : 32'($urandom_range(0, SZ - 1)),
                  mem_access_size_t'(2'($urandom_range(0, 2))));
        end

        @(posedge clk);
        #1 wr_enable = 1'b0;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/memory_array.md
# memory_array

Byte-addressable on-chip RAM on the responder (slave) side of `memory_array_interface`. It answers asynchronous reads and commits clocked writes of byte, halfword and word sizes. Accesses may be misaligned and may span a word boundary. After every reset, a built-in sequencer clears the array before any access is honoured. It sits behind the core's instruction/data memory masters, as the backing store in simulation and FPGA builds.

## Interface
Parameters:
- `SIZE`, default 65536: capacity in bytes; power of two, multiple of 4.
- `CLEAR_ON_RESET`, default 1: 1 runs the clear sequencer after reset; 0 leaves contents untouched and is ready immediately.

Ports:
- `clk`  input  1: clock.
- `reset`  input  1: synchronous, active-high.
- `mem`  `memory_array_interface.slave`  —: `rd_addr`/`rd_size` in, `rd_data` out; `wr_addr`/`wr_data`/`wr_size`/`wr_enable` in.
- `init_done`  output  1: array cleared and accepting accesses.

## Operation
- Storage is four byte banks, each `SIZE/4` rows. Byte address `a` maps to bank `a[1:0]`, row `a[log2(SIZE)-1:2]`.
- Address bits above `log2(SIZE)-1` are ignored; byte address `SIZE-1` wraps to 0.
- Access size uses `mem_access_size_t` from `definitions`: BYTE = 1 byte, HALF = 2 bytes, WORD = 4 bytes.
- Byte `i` of an access (i = 0..n-1) targets address `addr+i`, little-endian.
- An access that straddles a row boundary touches row r in the high banks and row r+1 in the low banks; no alignment is required.
- Read: `rd_data[8i+7:8i]` = byte at `rd_addr+i` for i < n; unused upper bytes are 0 (zero-extended). The core does sign extension.
- Write: on a `clk` edge with `wr_enable`=1 and `init_done`=1, byte `wr_data[8i+7:8i]` is stored at `wr_addr+i` for i < n. Other bytes are unchanged.
- Clear FSM states:
  - `CLEAR`: each cycle writes 0 to all four banks at row `clr_row`, then increments `clr_row`; moves to `READY` after writing row `SIZE/4-1`.
  - `READY`: normal operation; remains here until reset.
- With `CLEAR_ON_RESET`=0, reset enters `READY` directly.

## Timing
- Reset values:
  - `CLEAR_ON_RESET`=1: state = CLEAR, `clr_row` = 0, `init_done` = 0.
  - `CLEAR_ON_RESET`=0: state = READY, `init_done` = 1.
  - Array contents are not reset; only the sequencer clears them.
- `init_done` rises exactly `SIZE/4` cycles after the first cycle with `reset` low. It is a registered output.
- While `init_done`=0: `rd_data` = 32'h0 and writes are dropped.
- Reset asserted mid-clear restarts clearing from row 0.
- Reset asserted while READY clears the whole array again when `CLEAR_ON_RESET`=1.
- Read latency is 0: `rd_data` is combinational from `rd_addr`/`rd_size` and the current array contents.
- Write latency: data is visible to reads from the cycle after the write edge.
- A read and write to overlapping bytes in the same cycle returns the old data; there is no forwarding.
- One read and one write per cycle, fully independent. No stalls and no handshake.

## Structure
- `mem_access_size_t` and a size-to-byte-count function belong in `definitions`.
- Also add a `mem_access_size_t`-to-byte-count helper there, so masters can share it.
- Natural sub-module: `memory_array_bank`, one byte-wide bank with an asynchronous read port and a synchronous write port with write enable. It is instantiated four times.
- The top level contains the address rotation, per-bank row select (r or r+1), lane steering, and the clear FSM.

## Test plan
- Reset released with SIZE=64: `init_done` = 0 for cycles 0–15 and 1 from cycle 16. A WORD read at 0 during clear returns 0, and after clear returns 0.
- WORD write 32'hDEADBEEF at 0x10, then reads at 0x10: BYTE → 0x000000EF, HALF at 0x12 → 0x0000DEAD, WORD → 0xDEADBEEF.
- Misaligned WORD write 32'h11223344 at 0x0E (SIZE=64): WORD read at 0x0C → 0x33440000 and at 0x10 → 0x00001122.
- Wrap: HALF write 16'hA55A at 0x3F (SIZE=64): BYTE read at 0x3F → 0x5A and at 0x00 → 0xA5. Address 0x1003F aliases to 0x3F.
- Same-cycle WORD write 32'h1 and WORD read at 0x20: the read returns the old value 0, and 1 on the next cycle. A write issued while `init_done`=0 is dropped.
- Reset pulsed at cycle 5 of clearing: `init_done` rises 16 cycles after reset deasserts. With `CLEAR_ON_RESET`=0, `init_done` = 1 on the first cycle after reset and prior contents are retained.
